fp_rnd_arb: RTL and testbench

//  Round-robin arbiter and two-stage pipeline sharing one combinational rounding unit among NREQ producers
//  (e.g. fma, div/sqrt, convert). Accepts packed rounding requests with valid/ready, registers the winner,

---
 rtl/fp_rnd_arb.sv | 77 +++++++
 tb/tb_fp_rnd_arb.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fp_rnd_arb.sv
// fp_rnd_arb: round-robin arbiter sharing one combinational rounding unit among NREQ producers
// through a two-stage (request register, result register) pipeline.
module fp_rnd_arb #(
    parameter int NREQ  = 2,
    parameter int RND_W = 87,
    parameter int RES_W = 69
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*RND_W-1:0] req_data,
    output logic [RND_W-1:0]      rnd_in,
    input  logic [RES_W-1:0]      rnd_out,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [RES_W-1:0]      resp_data,
    output logic                  busy
);
    localparam int PTR_W = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [PTR_W-1:0]  ptr, gnt_id, s1_id, s2_id;
    logic [2*NREQ-1:0] rot;
    logic              gnt_any, s1_valid, s2_valid, s2_adv, s1_load, accept;
    logic [RND_W-1:0]  s1_data;
    logic [RES_W-1:0]  s2_data;
    // rot[k] is requester (ptr+k) mod NREQ; lowest set k wins
    always_comb begin
        rot = {req_valid, req_valid} >> ptr;
        gnt_any = 1'b0;
        gnt_id = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_any = 1'b1;
                gnt_id = PTR_W'((int'(ptr) + k) % NREQ);
            end
        end
    end
    assign s2_adv     = ~s2_valid | resp_ready[s2_id];
    assign s1_load    = (~s1_valid | s2_adv) & ~flush & ~reset;
    assign accept     = s1_load & gnt_any;
    assign req_ready  = accept ? NREQ'(1) << gnt_id : '0;
    assign rnd_in     = s1_valid ? s1_data : '0;
    assign resp_valid = s2_valid ? NREQ'(1) << s2_id : '0;
    assign resp_data  = s2_data;
    assign busy       = s1_valid | s2_valid;
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr      <= '0;
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_id    <= '0;
            s2_id    <= '0;
            s1_data  <= '0;
            s2_data  <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= rnd_out;
                    s2_id   <= s1_id;
                end
            end
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= req_data[int'(gnt_id)*RND_W +: RND_W];
                s1_id    <= gnt_id;
                ptr      <= PTR_W'((int'(gnt_id) + 1) % NREQ);
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_rnd_arb.sv
// tb_fp_rnd_arb: table-driven cycle vectors for fp_rnd_arb with a behavioural rounding stub
// and an in-order response scoreboard.
module tb_fp_rnd_arb;
    logic        clock, reset, flush;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [173:0] req_data;
    logic [86:0] rnd_in, d0, d1;
    logic [68:0] rnd_out, resp_data, prev_data;
    logic [1:0]  prev_rspv;
    logic        busy, prev_stall;
    int          n_cmp, n_err, cnt0, cnt1;

    typedef struct packed {
        logic       rst, fl;
        logic [1:0] rv, rr, rdy, rspv;
        logic       busy;
    } vec_t;
    typedef struct {
        int          id;
        logic [68:0] data;
    } exp_t;
    exp_t sb[$];

    fp_rnd_arb #(.NREQ(2), .RND_W(87), .RES_W(69)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rnd_in(rnd_in), .rnd_out(rnd_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // {2'b0, sig, expo[13:0], mant[53:0], rema, fmt, rm, grs, snan, qnan, dbz, inf, zero, diff}
    function automatic logic [86:0] mk_pkt(input logic sig, input logic [13:0] expo,
                                           input logic [53:0] mant, input logic [1:0] fmt,
                                           input logic snan);
        return {2'b0, sig, expo, mant, 2'b0, fmt, 3'b0, 3'b0, snan, 5'b0};
    endfunction

    function automatic logic [86:0] gen(input int i, input int c);
        return mk_pkt(c[0], 14'(100 + c), 54'(32'h800000 | (i << 20) | c), 2'd0, 1'b0);
    endfunction

    // Stand-in rounding unit: exact repack of single/double fields, canonical NaN on snan
    function automatic logic [68:0] rnd_model(input logic [86:0] r);
        if (r[5]) return (r[13:12] == 2'd1) ? {64'h7FF8000000000000, 5'b10000}
                                            : {64'h7FC00000, 5'b10000};
        if (r[13:12] == 2'd0) return {32'h0, r[84], r[77:70], r[38:16], 5'b0};
        return {r[84], r[80:70], r[67:16], 5'b0};
    endfunction

    always_comb rnd_out = rnd_model(rnd_in);

    function automatic vec_t row(input logic rst, input logic fl, input logic [1:0] rv,
                                 input logic [1:0] rr, input logic [1:0] rdy,
                                 input logic [1:0] rspv, input logic bsy);
        return '{rst, fl, rv, rr, rdy, rspv, bsy};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        int   id;
        reset = v.rst;
        flush = v.fl;
        req_valid = v.rv;
        resp_ready = v.rr;
        req_data = {d1, d0};
        @(negedge clock);
        chk("req_ready", 128'(req_ready), 128'(v.rdy));
        chk("resp_valid", 128'(resp_valid), 128'(v.rspv));
        chk("busy", 128'(busy), 128'(v.busy));
        if (prev_stall) begin
            chk("stall_data", 128'(resp_data), 128'(prev_data));
            chk("stall_valid", 128'(resp_valid), 128'(prev_rspv));
        end
        if (v.rst || v.fl) begin
            sb.delete();
            prev_stall = 1'b0;
        end else begin
            id = resp_valid[1] ? 1 : 0;
            if ((resp_valid & resp_ready) != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_resp", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", 128'(id), 128'(e.id));
                    chk("resp_data", 128'(resp_data), 128'(e.data));
                end
            end
            if (req_ready[0]) begin sb.push_back('{0, rnd_model(d0)}); cnt0++; end
            if (req_ready[1]) begin sb.push_back('{1, rnd_model(d1)}); cnt1++; end
            prev_stall = (resp_valid != 2'b00) && ((resp_valid & resp_ready) == 2'b00);
            prev_data = resp_data;
            prev_rspv = resp_valid;
        end
        @(posedge clock);
        #1;
    endtask

    vec_t tbl[29];

    initial begin
        n_cmp = 0; n_err = 0; cnt0 = 0; cnt1 = 0;
        prev_stall = 1'b0; prev_data = '0; prev_rspv = '0;
        d0 = '0; d1 = '0; req_data = '0;
        tbl = '{
            row(1,0,2'b11,2'b11,2'b00,2'b00,0),
            row(0,0,2'b01,2'b11,2'b01,2'b00,0),
            row(0,0,2'b00,2'b11,2'b00,2'b00,1),
            row(0,0,2'b00,2'b11,2'b00,2'b01,1),
            row(0,0,2'b11,2'b11,2'b10,2'b00,0),
            row(0,0,2'b11,2'b11,2'b01,2'b00,1),
            row(0,0,2'b11,2'b11,2'b10,2'b10,1),
            row(0,0,2'b11,2'b11,2'b01,2'b01,1),
            row(0,0,2'b11,2'b00,2'b00,2'b10,1),
            row(0,0,2'b11,2'b00,2'b00,2'b10,1),
            row(0,0,2'b11,2'b01,2'b00,2'b10,1),
            row(0,0,2'b11,2'b00,2'b00,2'b10,1),
            row(0,0,2'b11,2'b00,2'b00,2'b10,1),
            row(0,0,2'b11,2'b11,2'b10,2'b10,1),
            row(0,0,2'b00,2'b11,2'b00,2'b01,1),
            row(0,0,2'b00,2'b11,2'b00,2'b10,1),
            row(0,0,2'b00,2'b11,2'b00,2'b00,0),
            row(0,0,2'b10,2'b00,2'b10,2'b00,0),
            row(0,0,2'b11,2'b00,2'b01,2'b00,1),
            row(0,0,2'b11,2'b00,2'b00,2'b10,1),
            row(0,1,2'b11,2'b00,2'b00,2'b10,1),
            row(0,0,2'b00,2'b11,2'b00,2'b00,0),
            row(0,0,2'b11,2'b11,2'b10,2'b00,0),
            row(0,0,2'b11,2'b11,2'b01,2'b00,1),
            row(1,0,2'b11,2'b11,2'b00,2'b10,1),
            row(0,0,2'b11,2'b11,2'b01,2'b00,0),
            row(0,0,2'b00,2'b11,2'b00,2'b00,1),
            row(0,0,2'b00,2'b11,2'b00,2'b01,1),
            row(0,0,2'b00,2'b11,2'b00,2'b00,0)
        };
        reset = 1'b1; flush = 1'b0; req_valid = '0; resp_ready = '0;
        @(posedge clock);
        #1;
        chk("reset_rnd_in", 128'(rnd_in), 128'(0));
        chk("reset_resp_data", 128'(resp_data), 128'(0));
        for (int k = 0; k < 29; k++) begin
            d0 = gen(0, cnt0);
            d1 = gen(1, cnt1);
            apply(tbl[k]);
        end
        // unit-value 1.0f from requester 0, two-edge latency
        chk("idle_rnd_in", 128'(rnd_in), 128'(0));
        d0 = mk_pkt(1'b0, 14'd127, 54'h800000, 2'd0, 1'b0);
        apply(row(0,0,2'b01,2'b11,2'b01,2'b00,0));
        chk("one_rnd_in", 128'(rnd_in), 128'(d0));
        apply(row(0,0,2'b00,2'b11,2'b00,2'b00,1));
        chk("one_resp_valid", 128'(resp_valid), 128'(2'b01));
        chk("one_resp_data", 128'(resp_data), 128'({64'h3F800000, 5'b0}));
        apply(row(0,0,2'b00,2'b11,2'b00,2'b01,1));
        apply(row(0,0,2'b00,2'b11,2'b00,2'b00,0));
        // signalling NaN, double format, from requester 1
        d1 = mk_pkt(1'b0, 14'h7FF, 54'h1, 2'd1, 1'b1);
        apply(row(0,0,2'b10,2'b11,2'b10,2'b00,0));
        apply(row(0,0,2'b00,2'b11,2'b00,2'b00,1));
        chk("snan_resp_valid", 128'(resp_valid), 128'(2'b10));
        chk("snan_resp_data", 128'(resp_data), 128'({64'h7FF8000000000000, 5'b10000}));
        apply(row(0,0,2'b00,2'b11,2'b00,2'b10,1));
        apply(row(0,0,2'b00,2'b11,2'b00,2'b00,0));
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
